// File: rtl/iot_byte_feeder_if.sv
// ---------------------------------------------------------------------------
// iot_byte_feeder_if
//   Upstream word handshake into the IoT byte feeder.
//   Handshake: a word moves on a rising edge where s_valid and s_ready are
//   both high; s_valid/s_data must stay stable while s_valid is high and
//   s_ready is low; s_ready does not depend on s_valid.
//   Signals:
//     s_valid : producer has a valid word on s_data
//     s_data  : 128-bit sensor word
//     s_ready : feeder can accept a word this cycle
//   Modports: master = word producer, slave = feeder.
// ---------------------------------------------------------------------------
interface iot_byte_feeder_if;
    logic         s_valid;
    logic [127:0] s_data;
    logic         s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/iot_byte_feeder.sv
// ---------------------------------------------------------------------------
// iot_byte_feeder
//   Buffers 128-bit sensor words in a small FIFO and serialises each word,
//   MSB byte first, onto the filter's iot_in/in_en byte interface. Stalls on
//   busy, counts words in rounds of 8 and pulses round_done with the last
//   byte of every 8th word.
//   Ports:
//     clk        : rising-edge clock
//     rst        : asynchronous active-low reset
//     up         : upstream word handshake (slave side)
//     busy       : filter stall; no byte issued on an edge it is high
//     in_en      : iot_in carries a valid byte (registered)
//     iot_in     : byte to the filter (registered)
//     round_done : pulse with the last byte of every 8th word (registered)
//     fifo_cnt   : words held, including the word being sent
//     dbg_state  : current FSM state (0 IDLE, 1 SEND, 2 HOLD)
// ---------------------------------------------------------------------------
module iot_byte_feeder #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    iot_byte_feeder_if.slave   up,
    input  logic               busy,
    output logic               in_en,
    output logic [7:0]         iot_in,
    output logic               round_done,
    output logic [CW-1:0]      fifo_cnt,
    output logic [1:0]         dbg_state
);

    localparam int AW = CW - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    logic [127:0]    mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [3:0]      bidx;
    logic [2:0]      word_cnt;
    logic [0:15][7:0] head;   // element 0 is the MSB byte of the head word
    logic            push;
    logic            issue;
    logic            pop;

    // Ready comes from the registered count only, so a same-cycle pop never
    // opens the door for a push into a full buffer.
    assign up.s_ready = (cnt < CW'(DEPTH));
    assign push       = up.s_valid && up.s_ready;
    assign head       = mem[rptr];
    assign issue      = (state != IDLE) && !busy && (cnt != '0);
    assign pop        = issue && (bidx == 4'd15);
    assign fifo_cnt   = cnt;
    assign dbg_state  = state;

    always_comb begin
        cnt_next = cnt;
        if (push && !pop) begin
            cnt_next = cnt + 1'b1;
        end else if (pop && !push) begin
            cnt_next = cnt - 1'b1;
        end
    end

    // Storage is not reset: contents are meaningless once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= up.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            bidx       <= '0;
            word_cnt   <= '0;
            in_en      <= 1'b0;
            iot_in     <= 8'h00;
            round_done <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            in_en      <= 1'b0;
            round_done <= 1'b0;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end

            case (state)
                IDLE: begin
                    // Moving on the push edge lets byte 0 go out one edge later.
                    if (push) begin
                        state <= SEND;
                    end
                end
                SEND, HOLD: begin
                    if (busy) begin
                        // iot_in keeps its last value; bidx is untouched.
                        state <= HOLD;
                    end else if (issue) begin
                        in_en  <= 1'b1;
                        iot_in <= head[bidx];
                        bidx   <= bidx + 1'b1;
                        if (bidx == 4'd15) begin
                            word_cnt   <= word_cnt + 1'b1;
                            round_done <= (word_cnt == 3'd7);
                            // A push on this same edge keeps the stream gapless.
                            state      <= (cnt_next == '0) ? IDLE : SEND;
                        end else begin
                            state <= SEND;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iot_byte_feeder.sv
// ---------------------------------------------------------------------------
// tb_iot_byte_feeder
//   Directed bench for iot_byte_feeder. Each accepted word pushes its 16
//   expected {round_done, byte} pairs into exp_q; a negedge monitor pops and
//   compares whenever in_en is high.
// ---------------------------------------------------------------------------
module tb_iot_byte_feeder;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          busy = 1'b0;
    logic          in_en;
    logic [7:0]    iot_in;
    logic          round_done;
    logic [CW-1:0] fifo_cnt;
    logic [1:0]    dbg_state;
    int unsigned   cyc = 0;

    iot_byte_feeder_if sif ();

    iot_byte_feeder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .up         (sif.slave),
        .busy       (busy),
        .in_en      (in_en),
        .iot_in     (iot_in),
        .round_done (round_done),
        .fifo_cnt   (fifo_cnt),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    int checks = 0;
    int errors = 0;
    int words_pushed = 0;
    int cur_run = 0;
    int max_run = 0;
    int rounds_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void expect_word(input logic [127:0] w);
        words_pushed++;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = w[127 - 8*i -: 8];
            exp_q.push_back({(i == 15) && (words_pushed % 8 == 0), b});
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (in_en) begin
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                if (round_done) rounds_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual %0h required none", iot_in);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("byte_stream", {23'd0, round_done, iot_in}, {23'd0, mon_e});
                end
            end else begin
                cur_run = 0;
                check("round_done_no_byte", {31'd0, round_done}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        busy = 1'b0;
        #1;
        exp_q.delete();
        words_pushed = 0;
        cur_run = 0;
        check("rst_in_en", {31'd0, in_en}, 32'd0);
        check("rst_iot_in", {24'd0, iot_in}, 32'd0);
        check("rst_round_done", {31'd0, round_done}, 32'd0);
        check("rst_fifo_cnt", {29'd0, fifo_cnt}, 32'd0);
        check("rst_s_ready", {31'd0, sif.s_ready}, 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Returns 1 time unit after the accepting edge.
    task automatic push_word(input logic [127:0] w);
        logic r;
        int n;
        n = 0;
        r = 1'b0;
        sif.s_valid = 1'b1;
        sif.s_data  = w;
        do begin
            @(negedge clk);
            r = sif.s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 500);
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual not_accepted required accepted");
        end else begin
            expect_word(w);
        end
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_en || fifo_cnt != '0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", {31'd0, (n >= 3000)}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] t2_word(input int i);
        return {16{8'(8'h80 + i)}} ^ 128'h000102030405060708090A0B0C0D0E0F;
    endfunction

    // ---------------- stimulus ----------------
    logic [127:0] w0 = 128'h000102030405060708090A0B0C0D0E0F;
    logic [127:0] wa = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    logic [127:0] wb = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
    logic [127:0] wc = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    logic [127:0] wd = 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF;
    logic [127:0] w3 = 128'h303132333435363738393A3B3C3D3E3F;

    initial begin
        int hs;
        int r0;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;

        // 1: single word, exact latency and length
        do_reset();
        push_word(w0);
        @(negedge clk);
        check("t1_first_cycle_in_en", {31'd0, in_en}, 32'd0);
        check("t1_cnt_after_push", {29'd0, fifo_cnt}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("t1_in_en_high", {31'd0, in_en}, 32'd1);
        end
        @(negedge clk);
        check("t1_in_en_low_after", {31'd0, in_en}, 32'd0);
        check("t1_cnt_empty", {29'd0, fifo_cnt}, 32'd0);
        wait_idle();

        // 2: eight gapless words, one round pulse; then restart of the count
        do_reset();
        max_run = 0;
        r0 = rounds_seen;
        for (int i = 0; i < 8; i++) push_word(t2_word(i));
        wait_idle();
        check("t2_run_len", max_run, 32'd128);
        check("t2_rounds", rounds_seen - r0, 32'd1);
        r0 = rounds_seen;
        push_word(t2_word(8));
        wait_idle();
        check("t2_no_round_9th", rounds_seen - r0, 32'd0);
        for (int i = 9; i < 16; i++) push_word(t2_word(i));
        wait_idle();
        check("t2_round_16th", rounds_seen - r0, 32'd1);

        // 3: busy for 3 edges while byte 5 is pending
        push_word(wa);
        repeat (5) @(posedge clk);
        #1;
        busy = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("t3_stall_in_en", {31'd0, in_en}, 32'd0);
            check("t3_stall_hold_byte", {24'd0, iot_in}, 32'h0000_00A4);
        end
        busy = 1'b0;
        @(negedge clk);
        check("t3_resume_byte", {24'd0, iot_in}, 32'h0000_00A5);
        wait_idle();

        // 4: fill while busy, then ready returns after the first pop
        busy = 1'b1;
        for (int i = 0; i < 4; i++) push_word(t2_word(32 + i));
        sif.s_valid = 1'b1;
        sif.s_data  = wb;
        repeat (3) begin
            @(negedge clk);
            check("t4_full_ready", {31'd0, sif.s_ready}, 32'd0);
            check("t4_full_cnt", {29'd0, fifo_cnt}, 32'd4);
            check("t4_hold_in_en", {31'd0, in_en}, 32'd0);
        end
        @(posedge clk);
        #1;
        busy = 1'b0;
        fork
            push_word(wb);
            begin
                repeat (15) @(posedge clk);
                @(negedge clk);
                check("t4_ready_before_pop", {31'd0, sif.s_ready}, 32'd0);
                @(negedge clk);
                check("t4_ready_after_pop", {31'd0, sif.s_ready}, 32'd1);
                check("t4_cnt_after_pop", {29'd0, fifo_cnt}, 32'd3);
            end
        join
        wait_idle();

        // 5: push coincident with the pop, count stays 2, no bubble
        busy = 1'b1;
        push_word(wc);
        push_word(wd);
        @(posedge clk);
        #1;
        busy = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        push_word(wa);
        @(negedge clk);
        check("t5_cnt_same_edge", {29'd0, fifo_cnt}, 32'd2);
        check("t5_last_byte", {24'd0, iot_in}, 32'h0000_00CF);
        @(negedge clk);
        check("t5_no_bubble", {31'd0, in_en}, 32'd1);
        check("t5_next_byte0", {24'd0, iot_in}, 32'h0000_00D0);
        wait_idle();

        // 6: asynchronous reset at byte 9 of word 3, then a fresh round
        do_reset();
        push_word(wa);
        hs = int'(cyc);
        push_word(wb);
        push_word(w3);
        while (int'(cyc) < hs + 42) begin
            @(posedge clk);
            #1;
        end
        #1;
        check("t6_pre_reset_byte", {24'd0, iot_in}, 32'h0000_0039);
        do_reset();
        max_run = 0;
        r0 = rounds_seen;
        for (int i = 0; i < 8; i++) push_word(t2_word(64 + i));
        wait_idle();
        check("t6_run_len", max_run, 32'd128);
        check("t6_rounds", rounds_seen - r0, 32'd1);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iot_byte_feeder.md
# iot_byte_feeder

Upstream feeder for the IoT data filter stage. It accepts 128-bit sensor words over a valid/ready handshake and buffers them in a small FIFO. It serialises each word into 16 bytes, MSB byte first, on the filter's `iot_in`/`in_en` byte interface, and stalls whenever the filter asserts `busy`. It also counts words in rounds of 8, matching the filter's 8-word batch, and flags the final byte of each round.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO depth in 128-bit words; power of two, at least 2.
- `CW`, default 3: FIFO count width, equal to log2(DEPTH)+1.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `s_valid`, input, 1: the upstream word on `s_data` is valid.
- `s_data`, input, 128: upstream sensor word.
- `s_ready`, output, 1: FIFO can accept a word this cycle.
- `busy`, input, 1: filter stall request; no byte is issued on an edge where it is sampled high.
- `in_en`, output, 1: `iot_in` carries a valid byte this cycle; registered.
- `iot_in`, output, 8: byte to the filter; registered.
- `round_done`, output, 1: one-cycle pulse coincident with the last byte of every 8th word; registered.
- `fifo_cnt`, output, CW: number of words currently held in the FIFO, including the word being sent.

## Operation

- FIFO: circular buffer with write pointer, read pointer and count.
  - `s_ready` = (`fifo_cnt` < DEPTH). It is derived from the registered count only and ignores a same-cycle pop.
  - A push occurs when `s_valid` and `s_ready` are both high at an edge.
- Head word is sent in place from the FIFO entry under the read pointer. A 4-bit byte index `bidx` selects bits [127-8·bidx -: 8].
- State machine:
  - IDLE: FIFO empty.
    - Goes to SEND when `fifo_cnt` becomes non-zero.
  - SEND: at each edge where `busy`=0 and the FIFO is non-empty:
    - `in_en` <= 1, `iot_in` <= selected byte, `bidx` <= `bidx`+1 (wraps 15 -> 0).
    - When `bidx`==15, the head is popped and `word_cnt` increments.
    - The next word's byte 0 follows on the very next edge with no bubble.
    - If the FIFO is empty after the pop, the state goes to IDLE.
  - HOLD: entered from SEND at any edge where `busy`=1.
    - `in_en` <= 0, `iot_in` holds its last value, `bidx` and FIFO are unchanged.
    - Returns to SEND on the first edge with `busy`=0; that edge issues the held byte index.
  - In IDLE, `in_en` <= 0.
- Round counter: `word_cnt` is a 3-bit counter that wraps 7 -> 0.
  - `round_done` <= 1 on the edge that issues byte 15 while `word_cnt`==7; it is 0 otherwise.
- Simultaneous push and pop in one cycle is legal: count is unchanged and both pointers advance.
- Push while full cannot happen because `s_ready`=0. If `s_valid` is high while full, the word is not taken and upstream must hold it.
- Reset is asynchronous and can arrive mid-word or mid-round:
  - Clears pointers, `fifo_cnt`, `bidx`, `word_cnt` and state (to IDLE).
  - Buffered data and any partial word are discarded; no further bytes of that word are emitted.

## Timing

- Reset values: `in_en`=0, `iot_in`=8'h00, `round_done`=0, `fifo_cnt`=0, `s_ready`=1.
- Latency:
  - A word pushed at edge N into an empty FIFO with `busy` low has byte 0 driven with `in_en`=1 after edge N+1.
  - Byte 15 is driven after edge N+16.
- Throughput with `busy` low and data available: 1 byte per cycle, 16 cycles per word, gapless across words.
- `busy` takes effect on the edge it is sampled. Bytes already registered are not retracted, and no byte is lost or duplicated across a stall.
- `fifo_cnt` decrements on the edge that issues byte 15.

## Test plan

- Reset, then push one word 128'h000102...0F with `busy` low -> `in_en` high for exactly 16 cycles, `iot_in` = 00,01,...,0F in order, then `in_en`=0 and `fifo_cnt`=0.
- Push 8 back-to-back words with `busy` low -> 128 consecutive `in_en` cycles, and `round_done` high only alongside the 128th byte. A 9th word restarts the count, with the next pulse after 8 more words.
- Raise `busy` for 3 cycles while byte 5 of a word is pending -> `in_en`=0 for those 3 cycles, then bytes resume at index 5 with no byte skipped or repeated.
- Hold `s_valid` high with `busy` high -> 4 words accepted, then `s_ready`=0 and `fifo_cnt`=4. On release of `busy`, `s_ready` returns to 1 on the edge after the first pop.
- Push on the same edge as the pop of byte 15 with `fifo_cnt`=2 -> `fifo_cnt` stays 2 and the next word's byte 0 follows without a bubble.
- Assert `rst` low asynchronously at byte 9 of word 3 -> all outputs return to reset values immediately. After release and a new push, bytes start at index 0 and `round_done` first occurs after 8 new words.
